// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : enc_pkg
//  Purpose  : Shared constants and types for the convolutional encoder /
//             Viterbi decoder chain. Holds the generator polynomials for both
//             constraint lengths, the K limits and the mode enumeration.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package enc_pkg;

   // Generator polynomials, MSB taps the current input bit.
   localparam logic [5:0] G0_K6 = 6'o75;   // 111101 -> out[1] in K=6 mode
   localparam logic [5:0] G1_K6 = 6'o53;   // 101011 -> out[0] in K=6 mode
   localparam logic [2:0] G0_K3 = 3'o7;    // 111    -> out[1] in K=3 mode
   localparam logic [2:0] G1_K3 = 3'o5;    // 101    -> out[0] in K=3 mode

   localparam int K_MAX = 6;
   localparam int K_MIN = 3;

   typedef enum logic {
      CL_K3 = 1'b0,
      CL_K6 = 1'b1
   } constraint_len_e;

endpackage : enc_pkg
`default_nettype wire

// File: rtl/encoder_k6_conv_parity.sv
`default_nettype none
// ============================================================================
//  Module   : conv_parity
//  Purpose  : Combinational masked-XOR reduction of a K-bit input window with
//             a K-bit generator polynomial.
//             parity = XOR over i of (gen_i[K-1-i] & window_i[i])
//  Ports    : window_i [K-1:0] - window_i[0] is the current input bit,
//                                window_i[i] the bit from i cycles earlier
//             gen_i    [K-1:0] - generator, MSB taps window_i[0]
//             parity_o         - resulting parity bit
//  Revision : 1.0 - initial release
// ============================================================================
module conv_parity #(
   parameter int K = 6
) (
   input  logic [K-1:0] window_i,
   input  logic [K-1:0] gen_i,
   output logic         parity_o
);

   // Generator is written MSB-first (MSB = newest bit) while the window is
   // indexed newest-first from bit 0, so the generator is bit-reversed to
   // line the taps up before masking.
   logic [K-1:0] w_gen_rev;

   for (genvar i = 0; i < K; i++) begin : g_rev
      assign w_gen_rev[i] = gen_i[K-1-i];
   end

   assign parity_o = ^(w_gen_rev & window_i);

endmodule : conv_parity
`default_nettype wire

// File: rtl/encoder_k6.sv
`default_nettype none
// ============================================================================
//  Module   : encoder_k6
//  Purpose  : Rate-1/2 feed-forward convolutional encoder with run-time
//             selectable constraint length (K=6 or K=3). One input bit per
//             clock, two registered coded bits per clock, no handshake.
//  Ports    : clk                      - system clock, rising edge
//             rst_n                    - synchronous reset, active low
//             unencoded_bit            - data bit, sampled every edge
//             choose_constraint_length - 1 = K=6, 0 = K=3
//             out [1:0]                - {G0 parity, G1 parity}, registered
//  Revision : 1.0 - initial release
// ============================================================================
module encoder_k6 #(
   parameter logic [5:0] G0_K6 = enc_pkg::G0_K6,
   parameter logic [5:0] G1_K6 = enc_pkg::G1_K6,
   parameter logic [2:0] G0_K3 = enc_pkg::G0_K3,
   parameter logic [2:0] G1_K3 = enc_pkg::G1_K3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       unencoded_bit,
   input  logic       choose_constraint_length,
   output logic [1:0] out
);

   import enc_pkg::*;

   // s_q[0] is the previous input, s_q[i] the input from i+1 cycles ago.
   logic [K_MAX-2:0] s_q;
   logic [K_MAX-2:0] s_d;
   logic [1:0]       out_q;
   logic [1:0]       out_d;

   constraint_len_e  w_mode;
   logic [K_MAX-1:0] w_win6;
   logic [K_MIN-1:0] w_win3;
   logic             w_p0_k6;
   logic             w_p1_k6;
   logic             w_p0_k3;
   logic             w_p1_k3;

   assign w_mode = constraint_len_e'(choose_constraint_length);

   // Window bit 0 is the live input; older history follows in order. K=3
   // simply looks at the two newest history bits, the rest keep shifting.
   assign w_win6 = {s_q, unencoded_bit};
   assign w_win3 = {s_q[K_MIN-2:0], unencoded_bit};

   conv_parity #(.K(K_MAX)) u_par_g0_k6 (
      .window_i (w_win6),
      .gen_i    (G0_K6),
      .parity_o (w_p0_k6)
   );

   conv_parity #(.K(K_MAX)) u_par_g1_k6 (
      .window_i (w_win6),
      .gen_i    (G1_K6),
      .parity_o (w_p1_k6)
   );

   conv_parity #(.K(K_MIN)) u_par_g0_k3 (
      .window_i (w_win3),
      .gen_i    (G0_K3),
      .parity_o (w_p0_k3)
   );

   conv_parity #(.K(K_MIN)) u_par_g1_k3 (
      .window_i (w_win3),
      .gen_i    (G1_K3),
      .parity_o (w_p1_k3)
   );

   always_comb begin
      s_d   = {s_q[K_MAX-3:0], unencoded_bit};
      out_d = (w_mode == CL_K6) ? {w_p0_k6, w_p1_k6} : {w_p0_k3, w_p1_k3};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q   <= '0;
         out_q <= 2'b00;
      end else begin
         s_q   <= s_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule : encoder_k6
`default_nettype wire

// File: tb/tb_encoder_k6.sv
`default_nettype none
// ============================================================================
//  Module   : tb_encoder_k6
//  Purpose  : Directed self-checking bench for encoder_k6. Each step drives
//             reset/data/mode, waits one rising edge, then compares the
//             registered output against a hand-computed value.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_k6;

   logic       clk;
   logic       rst_n;
   logic       unencoded_bit;
   logic       choose_constraint_length;
   logic [1:0] out;

   int checks = 0;
   int errors = 0;

   encoder_k6 dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .unencoded_bit            (unencoded_bit),
      .choose_constraint_length (choose_constraint_length),
      .out                      (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs, clock once, sample 1 time unit after the edge and check.
   task automatic step(input logic rn, input logic din, input logic mode,
                       input logic [1:0] exp_out, input string tag);
      rst_n                    = rn;
      unencoded_bit            = din;
      choose_constraint_length = mode;
      @(posedge clk);
      #1;
      checks++;
      assert (out === exp_out)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, out, exp_out);
      end
   endtask

   initial begin
      rst_n                    = 1'b0;
      unencoded_bit            = 1'b1;
      choose_constraint_length = 1'b0;
      #2;

      // Reset held for three edges with data = 1; first post-reset edge
      // with data 0 must still give 00 (history cleared).
      step(1'b0, 1'b1, 1'b0, 2'b00, "rst_hold0");
      step(1'b0, 1'b1, 1'b0, 2'b00, "rst_hold1");
      step(1'b0, 1'b1, 1'b0, 2'b00, "rst_hold2");
      step(1'b1, 1'b0, 1'b0, 2'b00, "rst_release");

      // K=3 impulse
      step(1'b0, 1'b0, 1'b0, 2'b00, "k3imp_rst");
      step(1'b1, 1'b1, 1'b0, 2'b11, "k3imp0");
      step(1'b1, 1'b0, 1'b0, 2'b10, "k3imp1");
      step(1'b1, 1'b0, 1'b0, 2'b11, "k3imp2");
      step(1'b1, 1'b0, 1'b0, 2'b00, "k3imp3");

      // K=6 impulse: column-wise read of 111101 / 101011
      step(1'b0, 1'b0, 1'b1, 2'b00, "k6imp_rst");
      step(1'b1, 1'b1, 1'b1, 2'b11, "k6imp0");
      step(1'b1, 1'b0, 1'b1, 2'b10, "k6imp1");
      step(1'b1, 1'b0, 1'b1, 2'b11, "k6imp2");
      step(1'b1, 1'b0, 1'b1, 2'b10, "k6imp3");
      step(1'b1, 1'b0, 1'b1, 2'b01, "k6imp4");
      step(1'b1, 1'b0, 1'b1, 2'b11, "k6imp5");
      step(1'b1, 1'b0, 1'b1, 2'b00, "k6imp6");

      // K=3 data 1,0,1,1
      step(1'b0, 1'b0, 1'b0, 2'b00, "k3dat_rst");
      step(1'b1, 1'b1, 1'b0, 2'b11, "k3dat0");
      step(1'b1, 1'b0, 1'b0, 2'b10, "k3dat1");
      step(1'b1, 1'b1, 1'b0, 2'b00, "k3dat2");
      step(1'b1, 1'b1, 1'b0, 2'b01, "k3dat3");

      // Reset mid-stream in K=6: residue must not leak into the restart
      step(1'b0, 1'b0, 1'b1, 2'b00, "mid_rst0");
      step(1'b1, 1'b1, 1'b1, 2'b11, "mid_in0");
      step(1'b1, 1'b1, 1'b1, 2'b01, "mid_in1");
      step(1'b0, 1'b1, 1'b1, 2'b00, "mid_rst1");
      step(1'b1, 1'b1, 1'b1, 2'b11, "mid_re0");
      step(1'b1, 1'b0, 1'b1, 2'b10, "mid_re1");
      step(1'b1, 1'b0, 1'b1, 2'b11, "mid_re2");

      // Mode switch K=3 -> K=6: K=6 sees the bit shifted in during K=3
      step(1'b0, 1'b0, 1'b0, 2'b00, "sw_rst");
      step(1'b1, 1'b1, 1'b0, 2'b11, "sw_k3_0");
      step(1'b1, 1'b0, 1'b0, 2'b10, "sw_k3_1");
      step(1'b1, 1'b0, 1'b0, 2'b11, "sw_k3_2");
      step(1'b1, 1'b0, 1'b1, 2'b10, "sw_k6_3");
      step(1'b1, 1'b0, 1'b1, 2'b01, "sw_k6_4");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_encoder_k6
`default_nettype wire

// File: doc/encoder_k6.md
Name: encoder_k6

Overview:
- Rate-1/2 feed-forward convolutional encoder; one input bit per clock, two coded bits out per clock.
- Constraint length selectable at run time: K=6 (generators 75/53 octal) or K=3 (generators 7/5 octal).
- Sits at the transmit end of the encoder/decoder chain; feeds the matching Viterbi decoder.
- Bit-serial, no handshake; input is accepted every cycle.

Parameters:
- G0_K6, 6'o75, generator for out[1] when K=6 (binary 111101, MSB = tap on current input).
- G1_K6, 6'o53, generator for out[0] when K=6 (binary 101011).
- G0_K3, 3'o7, generator for out[1] when K=3 (binary 111).
- G1_K3, 3'o5, generator for out[0] when K=3 (binary 101).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous reset, active low; takes effect on the clk rising edge.
- unencoded_bit  input  1  data bit to encode; sampled every rising edge.
- choose_constraint_length  input  1  1 = K=6, 0 = K=3; sampled every rising edge.
- out  output  2  coded pair; out[1] = G0 parity, out[0] = G1 parity; registered.

Behaviour:
- State: 5-bit history register s[4:0]. s[0] holds the most recent previous input; s[i] holds the input from i+1 cycles earlier.
- Window per edge: v[0] = unencoded_bit, v[i] = s[i-1] for i = 1..5.
- Parity rule: for a K-bit generator g, parity = XOR over i = 0..K-1 of (g[K-1-i] AND v[i]).
- K=6 uses v[0..5]. K=3 uses v[0..2] only; s[4:2] are ignored for the output.
- Rising edge with rst_n = 1:
  - out <= {parity(G0_sel), parity(G1_sel)}, where G*_sel is chosen by the current choose_constraint_length.
  - s <= {s[3:0], unencoded_bit}.
- Latency: out reflects the bit sampled at edge n from just after edge n until edge n+1.
- Reset: rising edge with rst_n = 0 sets s <= 0 and out <= 2'b00; the input bit on that edge is discarded.
- Reset mid-stream: history is fully cleared; encoding restarts from the all-zero state on the next non-reset edge.
- The history register always shifts all 5 bits, regardless of mode.
- Mode switch mid-stream: the new K applies from the edge where the change is sampled. No flush or state clear; K=6 after a switch uses the real 5-bit history, including bits shifted in while in K=3 mode.
- Trellis termination is the caller's responsibility: it feeds K-1 zero bits. The block adds no tail.
- No X propagation after reset; out is 2'b00 until the first encoded edge.

Decomposition:
- Shared package enc_pkg holds:
  - Generator constants G0_K6, G1_K6, G0_K3, G1_K3, used as parameter defaults and by the decoder.
  - Constants K_MAX = 6 and K_MIN = 3.
  - Enum constraint_len_e: CL_K3 = 1'b0, CL_K6 = 1'b1.
- One sub-module is natural: conv_parity, a combinational masked-XOR reduction of a window and a generator. It is instantiated four times (two per K), and the outputs are muxed by mode.

Test Plan:
- Reset: hold rst_n = 0 for 3 edges with unencoded_bit = 1 -> out = 00 throughout; history cleared; first edge after release with input 0 -> out = 00.
- K=3 impulse: after reset, mode 0, inputs 1,0,0,0 -> out sequence 11, 10, 11, 00.
- K=6 impulse: after reset, mode 1, inputs 1,0,0,0,0,0,0 -> out sequence 11, 10, 11, 10, 01, 11, 00.
- K=3 data: after reset, mode 0, inputs 1,0,1,1 -> out 11, 10, 00, 01.
- Reset mid-stream: K=6, inputs 1,1, then rst_n = 0 for one edge, then inputs 1,0,0 -> after reset out = 11, 10, 11 (impulse restart, no residue).
- Mode switch: after reset, mode 0, inputs 1,0,0; then mode 1, input 0 -> last out = 10 (K=6 taps v[3] = 1: G0 bit = 1, G1 bit = 0).
